// File: rtl/mem_stage_ctrl_if.sv
// Data-memory port bundle between the MEM-stage controller and the data memory.
// The controller is the master (issues requests), the memory is the slave.
interface mem_stage_ctrl_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_ready_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_ready_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory sequencer: launches one load/store per instruction,
// formats store lanes and load results, stalls the pipeline until the memory
// completes, and aborts through a watchdog if the memory never answers.
//
// state  | meaning
// IDLE   | no access in flight; decode EX/MEM access, flag illegal/misaligned
// ACCESS | request held on the memory port until ready or watchdog expiry
// DONE   | one un-stalled cycle so the pipeline advances; inputs ignored
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MemRead_i,
  input  logic               MemWrite_i,
  input  logic [2:0]         funct3_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic               stall_o,
  output logic [31:0]        ld_data_o,
  output logic               ld_valid_o,
  output logic               err_o,
  output logic               timeout_o,
  mem_stage_ctrl_if.master   mem
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  // Last watchdog count value before the abort fires.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [7:0]  wd_cnt_q;
  logic [31:0] ld_data_q;
  logic        ld_valid_q;
  logic        timeout_q;

  logic        access_req;
  logic        illegal_f3;
  logic        misaligned;
  logic        access_ok;
  logic        access_bad;
  logic        in_access;
  logic [31:0] shifted;
  logic [31:0] ld_data_d;
  logic [7:0]  wd_cnt_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  // Decode the incoming access: legality of funct3 and natural alignment.
  always_comb begin
    access_req = MemRead_i | MemWrite_i;
    illegal_f3 = (funct3_i == 3'b011) || (funct3_i == 3'b110) ||
                 (funct3_i == 3'b111) || (MemWrite_i && funct3_i[2]);
    misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                 ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    access_bad = access_req && (illegal_f3 || misaligned);
    access_ok  = access_req && !illegal_f3 && !misaligned;
  end

  // Load path: align the returned word to the addressed byte, then extend.
  always_comb begin
    shifted   = mem.mem_rdata_i >> {addr_q[1:0], 3'b000};
    ld_data_d = shifted;
    case (funct3_q)
      3'b000:  ld_data_d = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data_d = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data_d = {24'h0, shifted[7:0]};
      3'b101:  ld_data_d = {16'h0, shifted[15:0]};
      default: ld_data_d = shifted;
    endcase
  end

  // Store path: byte enables from size and offset, data replicated per lane.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = '0;
    if (we_q) begin
      wdata_d = wdata_q;
      case (funct3_q[1:0])
        2'b00: begin
          be_d    = 4'b0001 << addr_q[1:0];
          wdata_d = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          be_d    = 4'b0011 << addr_q[1:0];
          wdata_d = {2{wdata_q[15:0]}};
        end
        default: be_d = 4'b1111;
      endcase
    end
  end

  assign wd_cnt_d = wd_cnt_q + 8'd1;

  // Sequencer: latches the access, waits for ready or watchdog, registers results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      we_q       <= 1'b0;
      wd_cnt_q   <= '0;
      ld_data_q  <= '0;
      ld_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      ld_data_q  <= '0;
      ld_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (access_ok) begin
            addr_q   <= addr_i;
            wdata_q  <= wdata_i;
            funct3_q <= funct3_i;
            we_q     <= MemWrite_i;
            wd_cnt_q <= '0;
            state_q  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (mem.mem_ready_i) begin
            state_q <= S_DONE;
            if (!we_q) begin
              ld_data_q  <= ld_data_d;
              ld_valid_q <= 1'b1;
            end
          end else if (wd_cnt_q == TO_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            wd_cnt_q <= wd_cnt_d;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_access = (state_q == S_ACCESS);

  // Bus outputs are forced to zero outside ACCESS so the port idles cleanly.
  assign mem.mem_req_o   = in_access;
  assign mem.mem_we_o    = in_access & we_q;
  assign mem.mem_addr_o  = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem.mem_wdata_o = in_access ? wdata_d : 32'h0;
  assign mem.mem_be_o    = in_access ? be_d : 4'b0000;

  // Reset gating keeps the decode-cycle outputs low while rst is held.
  assign stall_o    = !rst && (in_access || ((state_q == S_IDLE) && access_ok));
  assign err_o      = !rst && (state_q == S_IDLE) && access_bad;
  assign ld_data_o  = ld_data_q;
  assign ld_valid_o = ld_valid_q;
  assign timeout_o  = timeout_q;

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Sequences the MEM-stage data-memory access for loads and stores latched in the EX/MEM pipeline register. It drives the data-memory port, which has variable latency and a req/ready handshake. It formats byte lanes for stores, extracts and extends load data, and stalls the pipeline until the access completes. It sits between the EX/MEM register outputs and the data memory, and feeds load data to the MEM/WB register.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles spent in ACCESS without mem_ready_i before the access is aborted (1..255)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
MemRead_i  in  1  load in MEM stage (from EX/MEM)
MemWrite_i  in  1  store in MEM stage (from EX/MEM)
funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr_i  in  32  byte address (ALU result)
wdata_i  in  32  store data (rs2 value)
stall_o  out  1  freeze IF/ID/EX and the EX/MEM register
ld_data_o  out  32  formatted load result
ld_valid_o  out  1  one-cycle pulse: ld_data_o valid
err_o  out  1  one-cycle pulse: misaligned access or illegal funct3
timeout_o  out  1  one-cycle pulse: access aborted by watchdog
mem_req_o  out  1  memory request
mem_we_o  out  1  1 = write
mem_addr_o  out  32  word address {addr[31:2],2'b00}
mem_wdata_o  out  32  lane-replicated store data
mem_be_o  out  4  byte enables
mem_ready_i  in  1  memory completes the access this cycle
mem_rdata_i  in  32  read word, valid with mem_ready_i

Behaviour:
- Reset (asynchronous, immediate): state IDLE, watchdog counter 0. All outputs 0, including mem_req_o, which drops even mid-access.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no MemRead_i/MemWrite_i: all outputs 0.
- IDLE, access present, legal and aligned:
  - latch addr, wdata, funct3 and we; MemWrite_i wins if both are set
  - go to ACCESS
  - stall_o = 1 combinationally in this same cycle
- Illegal or misaligned access:
  - illegal funct3 = 011/110/111, or 1xx on a store
  - misaligned = H/HU with addr[0]=1, or W with addr[1:0]!=0
  - response: err_o pulses 1 cycle, no memory request, stall_o = 0, stay IDLE
- ACCESS:
  - mem_req_o = 1 and stall_o = 1
  - mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o held stable from the latched values
  - the watchdog counter increments each cycle without ready
- Completion: on mem_ready_i go to DONE. For a load, also register ld_data_o and pulse ld_valid_o in the DONE cycle. mem_req_o deasserts in DONE.
- Timeout: the counter reaches TIMEOUT_CYCLES with no ready. timeout_o pulses, ld_data_o = 0, no ld_valid_o, go to DONE.
- DONE: stall_o = 0 for exactly one cycle so the pipeline advances, then IDLE unconditionally. New MemRead_i/MemWrite_i are ignored in DONE, so the same instruction is never re-issued.
- Store lanes, with o = addr[1:0]:
  - SB: be = 0001<<o, data = {4{wdata[7:0]}}
  - SH: be = 0011<<o, data = {2{wdata[15:0]}}
  - SW: be = 1111, data = wdata
- Loads: the memory returns the full word and mem_be_o = 1111 on reads. The result is (rdata >> 8*o), then:
  - B: sign-extend bit 7
  - BU: zero-extend from 8 bits
  - H: sign-extend bit 15
  - HU: zero-extend from 16 bits
  - W: unchanged
- mem_ready_i outside ACCESS is ignored.
- Minimum latency (ready in the first ACCESS cycle): stall_o is high 2 cycles (IDLE-detect, ACCESS), result in the 3rd.

Test Plan:
- LW addr 0x100, ready after 3 ACCESS cycles, rdata 0xDEADBEEF -> mem_addr 0x100, be 1111, stall_o high 4 cycles, ld_data 0xDEADBEEF with ld_valid pulse, DONE stall low 1 cycle.
- SB addr 0x203, wdata 0x000000A5, ready immediately -> mem_we 1, mem_addr 0x200, be 1000, wdata 0xA5A5A5A5, no ld_valid.
- LB addr 0x2, rdata 0x0080FF00 -> ld_data 0xFFFFFF80. LHU addr 0x2, same rdata -> 0x00000080.
- LW addr 0x102 or SH addr 0x101 -> err_o 1-cycle pulse, mem_req never asserted, stall_o 0.
- LW with mem_ready_i held 0, TIMEOUT_CYCLES=4 -> mem_req high 4 cycles, timeout_o pulse, ld_data 0, then DONE and IDLE.
- rst asserted in the 2nd ACCESS cycle -> mem_req_o and stall_o 0 immediately. After release, a new SW completes normally.
